// File: rtl/pc_fetch_pkg.sv
// Shared types and default parameters for the PC / fetch-sequencing stage.
// The widths here match the branch-target LUT that feeds the Target input.
package pc_fetch_pkg;

  localparam int DEF_PC_W = 10;
  localparam int DEF_CNT_W = 16;
  localparam int LUT_AW = 5;
  localparam logic [DEF_PC_W-1:0] DEF_START_PC = '0;

  typedef logic [LUT_AW-1:0] lut_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  // A jump is always taken; a branch is taken only on a true condition.
  function automatic logic branch_taken(input logic jump_en,
                                        input logic branch_en,
                                        input logic cond_flag);
    return jump_en | (branch_en & cond_flag);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all-ones.
// clear has priority over enable.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: start/halt FSM, next-PC selection
// (hold / load target / increment), taken-branch pulse, wrap flag, cycle count.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              CNT_W    = DEF_CNT_W,
  parameter logic [PC_W-1:0] START_PC = DEF_START_PC
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             JumpEn,
  input  logic             BranchEn,
  input  logic             CondFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             BranchTaken,
  output logic             PcWrap,
  output logic [CNT_W-1:0] CycleCnt
);

  state_e          state_q;
  state_e          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            taken_q;
  logic            taken_d;
  logic            wrap_q;
  logic            wrap_d;

  logic            start_acc;
  logic            cnt_en;
  logic            advance;
  logic            take;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (Halt)  state_d = HALTED;
      HALTED:  if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Running   = (state_q == RUN);
    Done      = (state_q == HALTED);
    cnt_en    = (state_q == RUN);
    start_acc = Start && ((state_q == IDLE) || (state_q == HALTED));
    // The PC moves only in RUN when neither Halt nor Stall holds it.
    advance   = (state_q == RUN) && !Halt && !Stall;
  end

  // ------------------------------------------------------------ datapath
  assign take = branch_taken(JumpEn, BranchEn, CondFlag);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    pc_d    = pc_q;
    taken_d = 1'b0;
    wrap_d  = wrap_q;
    if (start_acc) begin
      pc_d   = START_PC;
      wrap_d = 1'b0;
    end else if (advance) begin
      if (take) begin
        pc_d    = Target;
        taken_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
        if (&pc_q) begin
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q    <= START_PC;
      taken_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      wrap_q  <= wrap_d;
    end
  end

  assign PC          = pc_q;
  assign BranchTaken = taken_q;
  assign PcWrap      = wrap_q;

  // Cycles in RUN, including stall and halt cycles; saturates at all-ones.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (start_acc),
    .enable (cnt_en),
    .count  (CycleCnt)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl plus hand-written sequences
// for counter saturation and asynchronous reset in the middle of a run.
module tb_pc_fetch_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        JumpEn;
  logic        BranchEn;
  logic        CondFlag;
  logic [9:0]  Target;
  logic [9:0]  PC;
  logic        Running;
  logic        Done;
  logic        BranchTaken;
  logic        PcWrap;
  logic [15:0] CycleCnt;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(
    .PC_W     (10),
    .CNT_W    (16),
    .START_PC (10'd0)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Halt        (Halt),
    .Stall       (Stall),
    .JumpEn      (JumpEn),
    .BranchEn    (BranchEn),
    .CondFlag    (CondFlag),
    .Target      (Target),
    .PC          (PC),
    .Running     (Running),
    .Done        (Done),
    .BranchTaken (BranchTaken),
    .PcWrap      (PcWrap),
    .CycleCnt    (CycleCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  ctl;   // {Start, Halt, Stall, JumpEn, BranchEn, CondFlag}
    logic [9:0]  tgt;
    logic [9:0]  pc;
    logic [3:0]  flg;   // {Running, Done, BranchTaken, PcWrap}
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] ctl, input logic [9:0] tgt,
                              input logic [9:0] pc, input logic [3:0] flg,
                              input logic [15:0] cnt);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.pc = pc; v.flg = flg; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [9:0] tgt);
    {Start, Halt, Stall, JumpEn, BranchEn, CondFlag} = ctl;
    Target = tgt;
  endtask

  task automatic check_all(input string tag, input logic [9:0] pc,
                           input logic [3:0] flg, input logic [15:0] cnt);
    check({tag, ".pc"},      32'(PC),          32'(pc));
    check({tag, ".running"}, 32'(Running),     32'(flg[3]));
    check({tag, ".done"},    32'(Done),        32'(flg[2]));
    check({tag, ".btaken"},  32'(BranchTaken), 32'(flg[1]));
    check({tag, ".wrap"},    32'(PcWrap),      32'(flg[0]));
    check({tag, ".cnt"},     32'(CycleCnt),    32'(cnt));
  endtask

  initial begin
    // ctl bits: S H St J B C      flags: R D B W
    vecs.push_back(mk(6'b100000, 10'h000, 10'h000, 4'b1000, 16'd0));  // start
    vecs.push_back(mk(6'b000000, 10'h000, 10'h001, 4'b1000, 16'd1));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h002, 4'b1000, 16'd2));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h003, 4'b1000, 16'd3));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h004, 4'b1000, 16'd4));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h005, 4'b1000, 16'd5));
    vecs.push_back(mk(6'b010000, 10'h000, 10'h005, 4'b0100, 16'd6));  // halt
    vecs.push_back(mk(6'b000000, 10'h000, 10'h005, 4'b0100, 16'd6));
    vecs.push_back(mk(6'b100000, 10'h000, 10'h000, 4'b1000, 16'd0));  // restart
    vecs.push_back(mk(6'b000000, 10'h000, 10'h001, 4'b1000, 16'd1));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h002, 4'b1000, 16'd2));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h003, 4'b1000, 16'd3));
    vecs.push_back(mk(6'b000011, 10'h00D, 10'h00D, 4'b1010, 16'd4));  // br taken
    vecs.push_back(mk(6'b000000, 10'h000, 10'h00E, 4'b1000, 16'd5));
    vecs.push_back(mk(6'b000100, 10'h003, 10'h003, 4'b1010, 16'd6));  // jump
    vecs.push_back(mk(6'b000010, 10'h00D, 10'h004, 4'b1000, 16'd7));  // br not taken
    vecs.push_back(mk(6'b100000, 10'h000, 10'h005, 4'b1000, 16'd8));  // start in RUN
    vecs.push_back(mk(6'b000000, 10'h000, 10'h006, 4'b1000, 16'd9));
    vecs.push_back(mk(6'b000000, 10'h000, 10'h007, 4'b1000, 16'd10));
    vecs.push_back(mk(6'b001100, 10'h092, 10'h007, 4'b1000, 16'd11)); // stall+jump
    vecs.push_back(mk(6'b001100, 10'h092, 10'h007, 4'b1000, 16'd12));
    vecs.push_back(mk(6'b001100, 10'h092, 10'h007, 4'b1000, 16'd13));
    vecs.push_back(mk(6'b000100, 10'h092, 10'h092, 4'b1010, 16'd14));
    vecs.push_back(mk(6'b011100, 10'h055, 10'h092, 4'b0100, 16'd15)); // halt wins
    vecs.push_back(mk(6'b000000, 10'h000, 10'h092, 4'b0100, 16'd15));
    vecs.push_back(mk(6'b000100, 10'h055, 10'h092, 4'b0100, 16'd15)); // jump ignored
    vecs.push_back(mk(6'b100000, 10'h000, 10'h000, 4'b1000, 16'd0));  // restart
    vecs.push_back(mk(6'b000100, 10'h3FE, 10'h3FE, 4'b1010, 16'd1));
    vecs.push_back(mk(6'b000011, 10'h3FF, 10'h3FF, 4'b1010, 16'd2));  // back-to-back
    vecs.push_back(mk(6'b000000, 10'h000, 10'h000, 4'b1001, 16'd3));  // wrap
    vecs.push_back(mk(6'b000000, 10'h000, 10'h001, 4'b1001, 16'd4));
    vecs.push_back(mk(6'b010000, 10'h000, 10'h001, 4'b0101, 16'd5));
    vecs.push_back(mk(6'b100000, 10'h000, 10'h000, 4'b1000, 16'd0));  // clears wrap
    vecs.push_back(mk(6'b000110, 10'h020, 10'h020, 4'b1010, 16'd1));  // jump+branch
    vecs.push_back(mk(6'b000010, 10'h055, 10'h021, 4'b1000, 16'd2));

    Reset = 1'b1;
    drive(6'b000000, 10'h000);
    #12;
    check_all("reset", 10'h000, 4'b0000, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Idle with no Start: controls must not move anything.
    drive(6'b000111, 10'h123);
    @(posedge Clk); #1;
    check_all("idle", 10'h000, 4'b0000, 16'd0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].ctl, vecs[i].tgt);
      @(posedge Clk); #1;
      check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].flg, vecs[i].cnt);
    end

    // Saturation: hold the PC with Stall long enough to exceed 2^16 cycles.
    @(negedge Clk);
    drive(6'b001000, 10'h000);
    repeat (65540) @(posedge Clk);
    #1;
    check_all("sat", 10'h021, 4'b1000, 16'hFFFF);
    @(posedge Clk); #1;
    check("sat_hold.cnt", 32'(CycleCnt), 32'hFFFF);

    // Asynchronous reset mid-run, between clock edges.
    @(negedge Clk);
    drive(6'b000100, 10'h025);
    @(posedge Clk); #1;
    check_all("pre_rst", 10'h025, 4'b1010, 16'hFFFF);
    #2;
    Reset = 1'b1;
    #1;
    check_all("async_rst", 10'h000, 4'b0000, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(6'b000000, 10'h000);
    @(posedge Clk); #1;
    check_all("post_rst", 10'h000, 4'b0000, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage that sits directly downstream of the branch-target LUT and upstream of instruction memory. It holds the 10-bit PC and steps it each cycle. On a taken jump or branch it loads the LUT-supplied absolute target. It runs a start/halt handshake with the testbench or top level, and reports run state, a taken-branch pulse, a sticky wrap flag and a saturating cycle count.

Parameters:
PC_W, 10, PC and branch-target width (matches LUT Target width)
CNT_W, 16, cycle counter width
START_PC, 10'd0, PC value loaded on reset and on every accepted Start

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request to begin a program; sampled only in IDLE or HALTED
Halt  input  1  decoded halt instruction at current PC
Stall  input  1  hold PC this cycle (e.g. multi-cycle memory op)
JumpEn  input  1  decoded unconditional jump at current PC
BranchEn  input  1  decoded conditional branch at current PC
CondFlag  input  1  ALU condition result for the current branch
Target  input  PC_W  absolute branch target from the LUT
PC  output  PC_W  current fetch address to instruction memory
Running  output  1  high while state is RUN
Done  output  1  high while state is HALTED
BranchTaken  output  1  one-cycle pulse: PC was just loaded from Target
PcWrap  output  1  sticky flag: PC incremented past all-ones
CycleCnt  output  CNT_W  cycles spent in RUN since the last accepted Start

Behaviour:
- Reset (async, active-high, any state, including mid-run):
  - state=IDLE, PC=START_PC.
  - Running=0, Done=0, BranchTaken=0, PcWrap=0, CycleCnt=0.
- All outputs are registered or decoded from registered state; no combinational paths from inputs to outputs.
- States: IDLE, RUN, HALTED.
  - IDLE: Start=1 -> RUN, PC=START_PC, CycleCnt=0, PcWrap=0. Otherwise hold.
  - RUN: the instruction at PC is evaluated every cycle. The update takes effect at the next rising edge, with this priority:
    1. Halt -> HALTED; PC holds; Halt wins over Stall, Jump and Branch.
    2. Stall -> PC holds; JumpEn, BranchEn and CondFlag are ignored.
    3. JumpEn, or (BranchEn and CondFlag) -> PC=Target, BranchTaken=1 next cycle.
    4. Otherwise -> PC=PC+1 modulo 2^PC_W; if PC was all-ones, PcWrap is set.
  - In RUN, Start is ignored.
  - HALTED: Done=1, PC frozen at the halting address. Start=1 -> RUN with the same initialisation as from IDLE; Done falls the next cycle.
- BranchTaken is high for exactly one cycle per taken branch or jump. Back-to-back taken branches hold it high on consecutive cycles.
- BranchEn=1 with CondFlag=0 is a plain increment.
- JumpEn and BranchEn both high: treated as taken.
- CycleCnt:
  - Increments on every cycle where state==RUN, including stall cycles and the Halt cycle.
  - Saturates at all-ones; never wraps.
  - Cleared only by Reset or an accepted Start.
- PcWrap: cleared only by Reset or an accepted Start.
- Target is assumed stable and valid in any cycle where a taken branch or jump is decoded. The block does not check for X values.

Decomposition:
- Shared package pc_fetch_pkg holds:
  - the state enum (IDLE, RUN, HALTED);
  - PC_W and LUT address width 5;
  - START_PC default.
- One sub-module is natural: sat_counter (parameter CNT_W; ports clear, enable, count). It implements CycleCnt.
- Next-PC selection and the FSM stay in the top module.

Test Plan:
- Reset asserted at PC=0x025 mid-run -> PC=0x000, Running=0, Done=0, CycleCnt=0, all flags 0, without waiting for a clock edge.
- Start pulse, no control inputs for 5 cycles -> PC steps 0,1,2,3,4,5; Running=1; CycleCnt=5.
- At PC=3: BranchEn=1, CondFlag=1, Target=0x00D -> PC=0x00D next cycle, BranchTaken high one cycle. Repeat with CondFlag=0 -> PC=4, BranchTaken=0.
- At PC=7: Stall held 3 cycles with JumpEn=1 and Target=0x092 -> PC stays 7, no BranchTaken, CycleCnt +3. Stall then released with JumpEn=1 -> PC=0x092.
- At PC=0x092: Halt=1 together with Stall=1 -> HALTED, Done=1, PC holds 0x092, CycleCnt frozen. A Start pulse in RUN is ignored; Start in HALTED -> PC=0, Done=0, CycleCnt=0.
- Jump to Target=0x3FF, then one increment -> PC=0x000, PcWrap=1 and stays 1 until the next Start. Force CycleCnt to 0xFFFF in RUN -> it holds 0xFFFF.
